uart_image_loader: RTL

//  Receive side of the laptop<->FPGA UART link; reverse direction of the face-result sender.

---
 rtl/uart_img_pkg.sv | 14 +
 rtl/uart_idle_timer.sv | 31 +++
 rtl/uart_image_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_img_pkg.sv
// Shared types and constants for the UART image receive path and the detector wrapper.
package uart_img_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, RECV, CHECK, FULL} img_state_t;

    localparam logic [7:0] SYNC_BYTE0 = 8'hA5;
    localparam logic [7:0] SYNC_BYTE1 = 8'h5A;

    localparam int IMG_W_DEFAULT   = 160;
    localparam int IMG_H_DEFAULT   = 120;
    // 256 bytes at 540 clocks per byte
    localparam int TIMEOUT_DEFAULT = 138240;

endpackage

// File: rtl/uart_idle_timer.sv
// Silence watchdog: counts enabled cycles without a byte; expired is a combinational 1-cycle flag
// on the TIMEOUT_CYCLES-th consecutive idle cycle. No backpressure.
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 138240
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = enable && !clear && (cnt == LAST);

    // Held at zero while disabled so each armed period starts fresh
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_image_loader.sv
// Frames UART bytes (A5 5A sync) into a raster frame-buffer write stream; all outputs registered, write 1 cycle after byte.
// RTS drops while an image is held until image_release; optional trailer checksum under UART_IMG_CHECKSUM_EN.
module uart_image_loader
    import uart_img_pkg::*;
#(
    parameter int  IMG_W          = IMG_W_DEFAULT,
    parameter int  IMG_H          = IMG_H_DEFAULT,
    parameter int  TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    localparam int NUM_PIX        = IMG_W * IMG_H,
    localparam int ADDR_W         = $clog2(NUM_PIX)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        uart_data,
    input  logic              uart_data_rdy,
    output logic              fpga_can_receive,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    output logic              pix_we,
    output logic              image_start,
    output logic              image_ready,
    input  logic              image_release,
    output logic              frame_error
);

    localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W + 1)'(NUM_PIX - 1);

    img_state_t        state, state_n;
    logic [ADDR_W:0]   count, count_n;
    logic              timeout;
    logic              rts_n, we_n, start_n, ready_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_n;
`ifdef UART_IMG_CHECKSUM_EN
    logic [7:0]        sum, sum_n;
`endif

    uart_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (uart_data_rdy),
        .enable  (state == SYNC || state == RECV || state == CHECK),
        .expired (timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            count            <= '0;
            fpga_can_receive <= 1'b1;
            pix_addr         <= '0;
            pix_data         <= '0;
            pix_we           <= 1'b0;
            image_start      <= 1'b0;
            image_ready      <= 1'b0;
            frame_error      <= 1'b0;
`ifdef UART_IMG_CHECKSUM_EN
            sum              <= '0;
`endif
        end else begin
            state            <= state_n;
            count            <= count_n;
            fpga_can_receive <= rts_n;
            pix_addr         <= addr_n;
            pix_data         <= data_n;
            pix_we           <= we_n;
            image_start      <= start_n;
            image_ready      <= ready_n;
            frame_error      <= err_n;
`ifdef UART_IMG_CHECKSUM_EN
            sum              <= sum_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
`ifdef UART_IMG_CHECKSUM_EN
        sum_n   = sum;
`endif
        if (timeout) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: if (uart_data_rdy && uart_data == SYNC_BYTE0) state_n = SYNC;
                SYNC: if (uart_data_rdy) begin
                    if (uart_data == SYNC_BYTE1) begin
                        state_n = RECV;
                        count_n = '0;
`ifdef UART_IMG_CHECKSUM_EN
                        sum_n   = '0;
`endif
                    end else if (uart_data != SYNC_BYTE0) begin
                        state_n = IDLE;
                    end
                end
                RECV: if (uart_data_rdy) begin
                    count_n = count + 1'b1;
`ifdef UART_IMG_CHECKSUM_EN
                    sum_n   = sum + uart_data;
                    if (count == LAST_PIX) state_n = CHECK;
`else
                    if (count == LAST_PIX) state_n = FULL;
`endif
                end
`ifdef UART_IMG_CHECKSUM_EN
                CHECK: if (uart_data_rdy) state_n = (uart_data == sum) ? FULL : IDLE;
`endif
                FULL: if (image_release) begin
                    state_n = IDLE;
                    count_n = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Level outputs follow the next state so they line up exactly with the registered state
    always_comb begin
        we_n    = (state == RECV) && uart_data_rdy;
        addr_n  = we_n ? count[ADDR_W-1:0] : pix_addr;
        data_n  = we_n ? uart_data : pix_data;
        rts_n   = (state_n != FULL);
        ready_n = (state_n == FULL);
        start_n = (state_n == FULL) && (state != FULL);
        err_n   = timeout || ((state == FULL) && uart_data_rdy);
`ifdef UART_IMG_CHECKSUM_EN
        if ((state == CHECK) && uart_data_rdy && (uart_data != sum)) err_n = 1'b1;
`endif
    end

endmodule
